mem_arbiter: RTL and testbench

- Parametrised successor to the two-requester memory controller.
- Arbitrates N_CH request channels (fetch, LSB, future prefetch/DMA) onto the single byte-wide RAM/IO bus.
- Serialises 1/2/4-byte reads and writes into byte cycles, assembles little-endian read words, and gates IO writes on io_buffer_full.
- Sits between the front-end/LSB requesters and the top-level mem_* pins.

---
 rtl/mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: N_CH-channel arbiter serialising 1/2/4-byte requests onto a byte-wide RAM/IO bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; fixed priority (channel 0 first) otherwise.
module mem_arbiter #(
   parameter int unsigned N_CH   = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned IO_GAP = 1
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic [N_CH-1:0]        req_valid,
   input  logic [N_CH-1:0]        req_wr,
   input  logic [N_CH*ADDR_W-1:0] req_addr,
   input  logic [N_CH*2-1:0]      req_len,
   input  logic [N_CH*32-1:0]     req_wdata,
   input  logic [N_CH-1:0]        flush_in,
   output logic [N_CH-1:0]        req_ready,
   output logic [N_CH-1:0]        resp_valid,
   output logic [31:0]            resp_data,
   input  logic [7:0]             mem_din,
   output logic [7:0]             mem_dout,
   output logic [ADDR_W-1:0]      mem_a,
   output logic                   mem_wr,
   input  logic                   io_buffer_full
);
   localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [2:0] {IDLE, READ, WRITE, IO_WAIT, GAP} state_t;
   state_t state_q, state_d;

   logic [CW-1:0]     ch_q, gsel;
   logic [ADDR_W-1:0] addr_q, mem_a_q, nxt_a, sel_addr;
   logic [31:0]       wdata_q, rdata_q, sel_wdata;
   logic [1:0]        sel_len, gap_q, cap_idx;
   logic [2:0]        cnt_q, n_q;
   logic              is_io_q, stalled_q;
   logic [N_CH-1:0]   resp_valid_q, elig, ready_c;
   logic              found, replay, adv, grant, rd_step, cap, wr_byte, fin, gap_ld;
`ifdef MEM_ARB_RR_EN
   logic [CW-1:0]     ptr_q;
`endif

   function automatic logic [2:0] len_bytes(input logic [1:0] l);
      return l[1] ? 3'd4 : (l[0] ? 3'd2 : 3'd1);
   endfunction

   assign elig      = req_valid & ~flush_in;
   assign sel_addr  = req_addr[gsel*ADDR_W +: ADDR_W];
   assign sel_len   = req_len[gsel*2 +: 2];
   assign sel_wdata = req_wdata[gsel*32 +: 32];
   // After a stall, one replay cycle re-issues the byte whose data capture was lost
   assign replay    = stalled_q & rdy_in;
   assign adv       = rdy_in & ~stalled_q;
   assign cap_idx   = cnt_q[1:0] - 2'd1;
   assign nxt_a     = addr_q + ADDR_W'(cnt_q + 3'd1);

   always_comb begin
      logic [CW-1:0] idx;
      found = 1'b0;
      gsel  = '0;
      idx   = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
`ifdef MEM_ARB_RR_EN
         idx = CW'((32'(ptr_q) + i) % N_CH);
`else
         idx = CW'(i);
`endif
         if (!found && elig[idx]) begin
            found = 1'b1;
            gsel  = idx;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready_c = '0;
      mem_wr  = 1'b0;
      grant   = 1'b0;
      rd_step = 1'b0;
      cap     = 1'b0;
      wr_byte = 1'b0;
      fin     = 1'b0;
      gap_ld  = 1'b0;
      case (state_q)
         IDLE: begin
            if (adv && found) begin
               grant          = 1'b1;
               ready_c[gsel]  = 1'b1;
               state_d        = req_wr[gsel] ? WRITE : READ;
            end
         end
         READ: begin
            if (rdy_in && flush_in[ch_q]) begin
               state_d = IDLE;
            end else if (adv) begin
               rd_step = 1'b1;
               cap     = (cnt_q != 3'd0);
               if (cnt_q == n_q) begin
                  fin     = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WRITE, IO_WAIT: begin
            if (adv) begin
               if (is_io_q && io_buffer_full) begin
                  state_d = IO_WAIT;
               end else begin
                  mem_wr  = 1'b1;
                  wr_byte = 1'b1;
                  if (is_io_q && IO_GAP != 32'd0) begin
                     gap_ld  = 1'b1;
                     state_d = GAP;
                  end else if (cnt_q == n_q - 3'd1) begin
                     fin     = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = WRITE;
                  end
               end
            end
         end
         GAP: begin
            if (adv && gap_q == 2'd1) begin
               if (cnt_q == n_q) begin
                  fin     = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WRITE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ch_q         <= '0;
         addr_q       <= '0;
         mem_a_q      <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
         n_q          <= '0;
         gap_q        <= '0;
         is_io_q      <= 1'b0;
         stalled_q    <= 1'b0;
         resp_valid_q <= '0;
`ifdef MEM_ARB_RR_EN
         ptr_q        <= '0;
`endif
      end else begin
         stalled_q <= (state_q != IDLE) && !rdy_in;
         if (rdy_in) begin
            resp_valid_q <= '0;
            if (fin) resp_valid_q[ch_q] <= 1'b1;
         end
         if (grant) begin
            ch_q    <= gsel;
            addr_q  <= sel_addr;
            mem_a_q <= sel_addr;
            wdata_q <= sel_wdata;
            n_q     <= len_bytes(sel_len);
            is_io_q <= (sel_addr[17:16] == 2'b11);
            cnt_q   <= '0;
            if (!req_wr[gsel]) rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= (32'(gsel) == N_CH - 1) ? '0 : CW'(gsel + 1'b1);
`endif
         end
         if (rd_step || wr_byte) begin
            cnt_q <= cnt_q + 3'd1;
            if ((cnt_q + 3'd1) < n_q) mem_a_q <= nxt_a;
         end
         if (cap) rdata_q[{cap_idx, 3'b000} +: 8] <= mem_din;
         if (gap_ld) gap_q <= 2'(IO_GAP);
         else if (state_q == GAP && adv && gap_q != 2'd0) gap_q <= gap_q - 2'd1;
      end
   end

   always_comb begin
      mem_a = mem_a_q;
      if (replay && state_q == READ)
         mem_a = (cnt_q == 3'd0) ? addr_q : addr_q + ADDR_W'(cap_idx);
   end

   assign req_ready  = ready_c & {N_CH{rst_in}};
   assign resp_valid = resp_valid_q;
   assign resp_data  = rdata_q;
   assign mem_dout   = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares them; cycle-exact bus checks run inline.
module tb_mem_arbiter;
   localparam int unsigned N_CH = 2;
   localparam int unsigned ADDR_W = 32;

   logic                   clk_in = 1'b0;
   logic                   rst_in, rdy_in;
   logic [N_CH-1:0]        req_valid, req_wr, flush_in;
   logic [N_CH*ADDR_W-1:0] req_addr;
   logic [N_CH*2-1:0]      req_len;
   logic [N_CH*32-1:0]     req_wdata;
   logic [N_CH-1:0]        req_ready, resp_valid;
   logic [31:0]            resp_data;
   logic [7:0]             mem_din, mem_dout;
   logic [ADDR_W-1:0]      mem_a;
   logic                   mem_wr, io_buffer_full;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  vec;
      logic        rd;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   mem_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .IO_GAP(1)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
      .req_len(req_len), .req_wdata(req_wdata), .flush_in(flush_in),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk_in = ~clk_in;

   // RAM contents: 0x100..0x103 hold 11 22 33 44
   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      logic [7:0] b;
      case (a[1:0])
         2'd0: b = 8'h11;
         2'd1: b = 8'h22;
         2'd2: b = 8'h33;
         default: b = 8'h44;
      endcase
      return b ^ {a[5:2], 4'h0};
   endfunction

   always @(posedge clk_in) mem_din <= ram_byte(mem_a);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin : monitor
      exp_t e;
      if (resp_valid !== '0) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: resp_valid=%b with nothing expected at %0t", resp_valid, $time);
         end else begin
            e = sb.pop_front();
            check("resp_chan", 32'(resp_valid), 32'(e.vec));
            if (e.rd) check("resp_data", resp_data, e.data);
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_in);
   endtask

   // Called in grant cycle G (just after posedge); returns in G+1 with req_valid dropped.
   task automatic issue(input int ch, input logic wr, input logic [31:0] addr, input logic [1:0] len,
                        input logic [31:0] wd, input logic exp_rsp, input logic [31:0] exp_data);
      exp_t e;
      int waited;
      req_wr[ch] = wr;
      req_addr[ch*32 +: 32] = addr;
      req_len[ch*2 +: 2] = len;
      req_wdata[ch*32 +: 32] = wd;
      req_valid[ch] = 1'b1;
      if (exp_rsp) begin
         e.vec = 2'(1 << ch);
         e.rd = !wr;
         e.data = exp_data;
         sb.push_back(e);
      end
      waited = 0;
      sample();
      while (req_ready[ch] !== 1'b1 && waited < 20) begin
         sample();
         waited++;
      end
      check("grant", 32'(req_ready[ch]), 32'd1);
      step();
      req_valid[ch] = 1'b0;
   endtask

   logic [1:0]  arb_vec[4];
   logic [31:0] arb_dat[4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int ngr;
      int cyc;
`ifdef MEM_ARB_RR_EN
      arb_vec = '{2'b01, 2'b10, 2'b01, 2'b10};
      arb_dat = '{32'h51, 32'h91, 32'h51, 32'h91};
`else
      arb_vec = '{2'b01, 2'b01, 2'b01, 2'b01};
      arb_dat = '{32'h51, 32'h51, 32'h51, 32'h51};
`endif
      rst_in = 1'b0; rdy_in = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0;
      req_len = '0; req_wdata = '0; flush_in = '0; io_buffer_full = 1'b0;

      // reset held with random inputs
      repeat (4) begin
         step();
         req_valid = 2'($urandom); req_wr = 2'($urandom); req_addr = {$urandom, $urandom};
         req_len = 4'($urandom); req_wdata = {$urandom, $urandom}; flush_in = 2'($urandom);
         io_buffer_full = 1'($urandom); rdy_in = 1'($urandom);
         sample();
         check("rst_req_ready", 32'(req_ready), 32'd0);
         check("rst_resp_valid", 32'(resp_valid), 32'd0);
         check("rst_resp_data", resp_data, 32'd0);
         check("rst_mem_wr", 32'(mem_wr), 32'd0);
         check("rst_mem_a", mem_a, 32'd0);
         check("rst_mem_dout", 32'(mem_dout), 32'd0);
      end
      step();
      req_valid = '0; req_wr = '0; flush_in = '0; io_buffer_full = 1'b0; rdy_in = 1'b1;
      step();
      rst_in = 1'b1;
      step();

      // channel 1 four-byte read at 0x100
      issue(1, 1'b0, 32'h100, 2'b10, 32'h0, 1'b1, 32'h44332211);
      for (int k = 0; k < 4; k++) begin
         sample();
         check("rd_addr", mem_a, 32'(32'h100 + k));
         check("rd_no_wr", 32'(mem_wr), 32'd0);
         step();
      end
      sample();
      check("rd_resp_early", 32'(resp_valid), 32'd0);
      step();
      sample();
      check("rd_resp_g6", 32'(resp_valid), 32'b10);
      step();

      // both channels contending with 1-byte reads, back to back
      for (int i = 0; i < 4; i++) begin
         e.vec = arb_vec[i]; e.rd = 1'b1; e.data = arb_dat[i];
         sb.push_back(e);
      end
      req_wr = '0; req_len = '0; req_addr = {32'h20, 32'h10}; req_valid = 2'b11;
      ngr = 0; cyc = 0;
      while (ngr < 4 && cyc < 40) begin
         sample();
         if (req_ready !== '0) begin
            check("arb_grant", 32'(req_ready), 32'(arb_vec[ngr]));
            ngr++;
         end
         step();
         cyc++;
      end
      req_valid = '0;
      check("arb_grant_count", 32'(ngr), 32'd4);
      repeat (4) step();

      // IO write of 0xBEEF with io_buffer_full high for 3 cycles
      io_buffer_full = 1'b1;
      issue(0, 1'b1, 32'h30000, 2'b01, 32'h0000BEEF, 1'b1, 32'h0);
      for (int k = 0; k < 3; k++) begin
         sample();
         check("io_wait_no_wr", 32'(mem_wr), 32'd0);
         step();
      end
      io_buffer_full = 1'b0;
      sample();
      check("io_b0_wr", 32'(mem_wr), 32'd1);
      check("io_b0_addr", mem_a, 32'h30000);
      check("io_b0_data", 32'(mem_dout), 32'hEF);
      step(); sample();
      check("io_gap_no_wr", 32'(mem_wr), 32'd0);
      step(); sample();
      check("io_b1_wr", 32'(mem_wr), 32'd1);
      check("io_b1_addr", mem_a, 32'h30001);
      check("io_b1_data", 32'(mem_dout), 32'hBE);
      step(); sample();
      check("io_gap2_no_wr", 32'(mem_wr), 32'd0);
      check("io_resp_early", 32'(resp_valid), 32'd0);
      step(); sample();
      check("io_resp", 32'(resp_valid), 32'b01);
      step();

      // flush channel 1 at G+3; channel 0 granted at G+4
      issue(1, 1'b0, 32'h200, 2'b10, 32'h0, 1'b0, 32'h0);
      step();
      step();
      flush_in = 2'b10;
      req_wr[0] = 1'b0; req_addr[31:0] = 32'h46; req_len[1:0] = 2'b00; req_valid[0] = 1'b1;
      e.vec = 2'b01; e.rd = 1'b1; e.data = 32'h23;
      sb.push_back(e);
      sample();
      check("flush_busy_no_grant", 32'(req_ready), 32'd0);
      step();
      flush_in = '0;
      sample();
      check("grant_after_flush", 32'(req_ready), 32'b01);
      step();
      req_valid = '0;
      step(); sample();
      check("flush_no_resp", 32'(resp_valid), 32'd0);
      step(); sample();
      check("post_flush_resp", 32'(resp_valid), 32'b01);
      step();

      // two-cycle rdy_in stall at G+2 of a four-byte read
      issue(1, 1'b0, 32'h100, 2'b10, 32'h0, 1'b1, 32'h44332211);
      step();
      rdy_in = 1'b0;
      sample();
      check("stall_no_wr_a", 32'(mem_wr), 32'd0);
      step(); sample();
      check("stall_no_wr_b", 32'(mem_wr), 32'd0);
      step();
      rdy_in = 1'b1;
      sample();
      check("replay_addr", mem_a, 32'h100);
      step(); sample();
      check("post_replay_addr", mem_a, 32'h101);
      repeat (3) step();
      sample();
      check("stall_resp_early", 32'(resp_valid), 32'd0);
      step(); sample();
      check("stall_resp_g9", 32'(resp_valid), 32'b10);
      step();

      // four-byte RAM write with a one-cycle stall at G+2
      issue(0, 1'b1, 32'h1000, 2'b10, 32'h11223344, 1'b1, 32'h0);
      sample();
      check("wr_b0_wr", 32'(mem_wr), 32'd1);
      check("wr_b0_addr", mem_a, 32'h1000);
      check("wr_b0_data", 32'(mem_dout), 32'h44);
      step();
      rdy_in = 1'b0;
      sample();
      check("wr_stall_no_wr", 32'(mem_wr), 32'd0);
      step();
      rdy_in = 1'b1;
      sample();
      check("wr_replay_no_wr", 32'(mem_wr), 32'd0);
      step(); sample();
      check("wr_b1_wr", 32'(mem_wr), 32'd1);
      check("wr_b1_addr", mem_a, 32'h1001);
      check("wr_b1_data", 32'(mem_dout), 32'h33);
      step(); step(); sample();
      check("wr_b3_addr", mem_a, 32'h1003);
      check("wr_b3_data", 32'(mem_dout), 32'h11);
      step(); sample();
      check("wr_resp", 32'(resp_valid), 32'b01);
      step();

      // two-byte read wrapping past the top of the address space
      issue(0, 1'b0, 32'hFFFF_FFFF, 2'b01, 32'h0, 1'b1, 32'h0000_11B4);
      sample();
      check("wrap_addr0", mem_a, 32'hFFFF_FFFF);
      step(); sample();
      check("wrap_addr1", mem_a, 32'h0);
      step(); step(); sample();
      check("wrap_resp", 32'(resp_valid), 32'b01);
      step();

      // reset asserted mid-read drops the transaction
      issue(1, 1'b0, 32'h100, 2'b10, 32'h0, 1'b0, 32'h0);
      step();
      rst_in = 1'b0;
      req_valid[0] = 1'b1;
      #1;
      check("midrst_mem_wr", 32'(mem_wr), 32'd0);
      check("midrst_mem_a", mem_a, 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      check("midrst_resp", 32'(resp_valid), 32'd0);
      step(); step();
      req_valid = '0;
      rst_in = 1'b1;
      repeat (6) step();
      sample();
      check("midrst_no_resp", 32'(resp_valid), 32'd0);
      check("midrst_idle_addr", mem_a, 32'd0);

      repeat (3) step();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
